// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution engine: width helpers,
// fixed-point rounding/saturation and the default window type.
package conv_pkg;

  localparam int DEF_K  = 3;
  localparam int DEF_DW = 16;

  typedef logic signed [DEF_K*DEF_K-1:0][DEF_DW-1:0] window_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_min_w(input int dw, input int cw, input int k);
    return dw + cw + $clog2(k * k);
  endfunction

  // Round half up, then arithmetic shift; done at 64 bits so the bias cannot overflow
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int frac);
    logic signed [63:0] bias;
    bias = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
    return (v + bias) >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// KERNEL_SIZE-1 line memories; presents the K-tall column (top = oldest row)
// for the current column address, bottom entry being the incoming pixel.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int MAX_WIDTH   = 64
) (
  input  logic                                          clk,
  input  logic signed [DATA_WIDTH-1:0]                  i_pix,
  input  logic [idx_w(MAX_WIDTH)-1:0]                   i_col,
  input  logic                                          i_adv,
  output logic signed [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] o_col
);

  logic signed [DATA_WIDTH-1:0] r_mem [KERNEL_SIZE-1][MAX_WIDTH];

  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_mem[0][i_col] <= i_pix;
      for (int j = 1; j < KERNEL_SIZE - 1; j++)
        r_mem[j][i_col] <= r_mem[j-1][i_col];
    end
  end

  always_comb begin
    o_col = '0;
    o_col[KERNEL_SIZE-1] = i_pix;
    for (int r = 0; r < KERNEL_SIZE - 1; r++)
      o_col[r] = r_mem[KERNEL_SIZE-2-r][i_col];
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution: line buffers, sliding window, 3-stage MAC with
// round/saturate. Define CONV_RELU_EN to clamp negative results to zero.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int KERNEL_SIZE = 3,
  parameter int MAX_WIDTH   = 64,
  parameter int STRIDE      = 1,
  parameter int FRAC_BITS   = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]                cfg_width,
  input  logic                                          coef_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]    coef_addr,
  input  logic signed [COEF_WIDTH-1:0]                  coef_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]                  in_data,
  input  logic                                          in_sof,
  input  logic                                          in_eol,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic signed [DATA_WIDTH-1:0]                  out_data,
  output logic                                          out_eol,
  output logic                                          line_err
);

  localparam int K  = KERNEL_SIZE;
  localparam int KK = K * K;
  localparam int CW = $clog2(MAX_WIDTH + 1);
  localparam int AW = idx_w(MAX_WIDTH);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int RW = 16;

  logic [CW-1:0] r_col, r_width, w_col, w_width, w_lastc;
  logic [RW-1:0] r_row, w_row;
  logic w_stall, w_acc, w_last, w_phase_ok, w_win_ok, w_weol;
  logic signed [COEF_WIDTH-1:0] r_shadow [KK];
  logic signed [COEF_WIDTH-1:0] r_active [KK];
  logic signed [K-1:0][DATA_WIDTH-1:0] w_cvec;
  logic signed [DATA_WIDTH-1:0] r_win [K][K-1];
  logic signed [PW-1:0] w_prod [KK];
  logic signed [PW-1:0] r_prod_p0 [KK];
  logic r_vld_p0, r_eol_p0, r_vld_p1, r_eol_p1;
  logic signed [ACC_WIDTH-1:0] w_sum, r_sum_p1;
  logic signed [63:0] w_rnd;
  logic signed [DATA_WIDTH-1:0] w_res;

  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;
  assign w_acc    = in_valid && in_ready;

  assign w_col   = in_sof ? '0 : r_col;
  assign w_row   = in_sof ? '0 : r_row;
  assign w_width = in_sof ? cfg_width : r_width;
  assign w_last  = (w_col == w_width - CW'(1));

  // K is odd, so (x-(K-1)) is even exactly when x is even
  assign w_phase_ok = (STRIDE == 1) || (!w_col[0] && !w_row[0]);
  assign w_win_ok   = w_acc && (w_row >= RW'(K-1)) && (w_col >= CW'(K-1)) && w_phase_ok;
  assign w_lastc    = w_width - CW'(1) - (((STRIDE == 2) && !w_width[0]) ? CW'(1) : CW'(0));
  assign w_weol     = (w_col == w_lastc);

  conv_line_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_SIZE (K),
    .MAX_WIDTH   (MAX_WIDTH)
  ) u_lb (
    .clk   (clk),
    .i_pix (in_data),
    .i_col (w_col[AW-1:0]),
    .i_adv (w_acc),
    .o_col (w_cvec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_width  <= CW'(MAX_WIDTH);
      line_err <= 1'b0;
    end else if (w_acc) begin
      r_width <= w_width;
      if (w_last || in_eol) begin
        r_col <= '0;
        r_row <= w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
      if (w_last != in_eol) line_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KK; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (coef_we && (int'(coef_addr) < KK)) r_shadow[coef_addr] <= coef_data;
      if (w_acc && in_sof) r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 2; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][K-2] <= $signed(w_cvec[r]);
      end
    end
  end

  always_comb begin
    w_prod = '{default: '0};
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++)
        w_prod[r*K+c] = PW'(r_win[r][c]) * PW'(r_active[r*K+c]);
      w_prod[r*K+K-1] = PW'($signed(w_cvec[r])) * PW'(r_active[r*K+K-1]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++) w_sum = w_sum + ACC_WIDTH'(r_prod_p0[i]);
  end

  always_comb begin
    w_rnd = round_shift(64'(r_sum_p1), FRAC_BITS);
    w_res = DATA_WIDTH'(sat_to(w_rnd, DATA_WIDTH));
`ifdef CONV_RELU_EN
    if (w_res[DATA_WIDTH-1]) w_res = '0;
`endif
  end

  // p0: products, p1: accumulated sum; both freeze while stalled
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_prod_p0 <= w_prod;
      r_eol_p0  <= w_weol;
      r_sum_p1  <= w_sum;
      r_eol_p1  <= r_eol_p0;
    end
  end

  // output stage: rounded/saturated result held until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
    end else if (!w_stall) begin
      r_vld_p0  <= w_win_ok;
      r_vld_p1  <= r_vld_p0;
      out_valid <= r_vld_p1;
      if (r_vld_p1) begin
        out_data <= w_res;
        out_eol  <= r_eol_p1;
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench: stride-1 and stride-2 engines fed the same accepted pixels.
module tb_conv_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [6:0] cfg_width;
  logic coef_we;
  logic [3:0] coef_addr;
  logic signed [15:0] coef_data;
  logic in_valid, in_ready, in_sof, in_eol;
  logic signed [15:0] in_data;
  logic out_valid, out_ready, out_eol, line_err;
  logic signed [15:0] out_data;
  logic in_valid2, in_ready2, out_valid2, out_ready2, out_eol2, line_err2;
  logic signed [15:0] out_data2;

  assign in_valid2  = in_valid && in_ready;
  assign out_ready2 = 1'b1;

  conv_stream_engine u_dut (
    .clk(clk), .reset(reset), .cfg_width(cfg_width), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eol(out_eol), .line_err(line_err));

  conv_stream_engine #(.STRIDE(2)) u_dut2 (
    .clk(clk), .reset(reset), .cfg_width(cfg_width), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_eol(out_eol2), .line_err(line_err2));

  typedef struct {
    longint d;
    bit     e;
    bit     dk;
    bit     lat;
    int     ac;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int img[16][64];
  bit known[16][64];
  int m_col, m_row, m_w;
  int shadow[9];
  int active[9];
  bit lat_next;
  bit rnd_en = 1'b0;
  bit prev_stall = 1'b0;
  logic signed [15:0] held_d;
  logic held_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint expect_val(input longint sum);
    longint v;
    v = (sum + 128) >>> 8;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef CONV_RELU_EN
    if (v < 0) v = 0;
`endif
    return v;
  endfunction

  function automatic bit is_last_col(input int c, input int s);
    int lc;
    lc = -1;
    for (int x = 2; x < m_w; x++) if (((x - 2) % s) == 0) lc = x;
    return c == lc;
  endfunction

  task automatic model_accept(input int d, input bit sof, input bit eol);
    if (sof) begin
      m_col = 0;
      m_row = 0;
      m_w = int'(cfg_width);
      active = shadow;
      foreach (known[i, j]) known[i][j] = 1'b0;
    end
    img[m_row][m_col] = d;
    known[m_row][m_col] = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      if (m_row >= 2 && m_col >= 2 && ((m_row - 2) % s) == 0 && ((m_col - 2) % s) == 0) begin
        exp_t e;
        longint sum;
        sum = 0;
        e.dk = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            sum += longint'(img[m_row-2+r][m_col-2+c]) * longint'(active[r*3+c]);
            e.dk &= known[m_row-2+r][m_col-2+c];
          end
        e.d = expect_val(sum);
        e.e = is_last_col(m_col, s);
        e.ac = cyc;
        e.lat = (s == 1) && lat_next;
        if (s == 1) begin
          lat_next = 1'b0;
          q1.push_back(e);
        end else q2.push_back(e);
      end
    end
    if (m_col == m_w - 1 || eol) begin
      m_col = 0;
      m_row++;
    end else m_col++;
  endtask

  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_d);
        chk("hold_eol", out_eol, held_e);
      end
      prev_stall = out_valid && !out_ready;
      held_d = out_data;
      held_e = out_eol;
      if (out_valid && out_ready) begin
        if (q1.size() == 0) chk("extra_result", out_valid, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          if (e.dk) chk("data", out_data, e.d);
          chk("eol", out_eol, e.e);
          if (e.lat) chk("latency", cyc - e.ac, 3);
        end
      end
      if (out_valid2) begin
        if (q2.size() == 0) chk("extra_result_s2", out_valid2, 0);
        else begin
          exp_t e;
          e = q2.pop_front();
          if (e.dk) chk("data_s2", out_data2, e.d);
          chk("eol_s2", out_eol2, e.e);
        end
      end
    end
  end

  task automatic send(input int d, input bit sof, input bit eol);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = 16'(d);
    in_sof = sof;
    in_eol = eol;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, sof, eol);
        done = 1'b1;
      end else if (++t > 1000) begin
        chk("send_timeout", in_ready, 1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wcoef(input int a, input int v);
    in_valid = 1'b0;
    coef_we = 1'b1;
    coef_addr = 4'(a);
    coef_data = 16'(v);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    shadow[a] = v;
  endtask

  task automatic frame(input int mode, input int base, input bit midwrite);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int d;
        if (midwrite && r == 4 && c == 0)
          for (int a = 0; a < 9; a++) wcoef(a, 512);
        d = (mode == 0) ? r * 8 + c : (mode == 1) ? base : int'($urandom_range(0, 600)) - 300;
        send(d, r == 0 && c == 0, c == 7);
      end
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    while ((q1.size() != 0 || q2.size() != 0) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_q1", q1.size(), 0);
    chk("drain_q2", q2.size(), 0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eol = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    cfg_width = 7'd8;
    out_ready = 1'b1;
    lat_next = 1'b0;
    m_col = 0;
    m_row = 0;
    m_w = 8;
    foreach (shadow[i]) begin
      shadow[i] = 0;
      active[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready_s2", in_ready2, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // identity kernel over a ramp
    wcoef(4, 256);
    lat_next = 1'b1;
    frame(0, 0, 1'b0);
    drain();
    chk("line_err_clean", line_err, 0);

    // all-ones kernel: positive saturation, then small negative
    for (int a = 0; a < 9; a++) wcoef(a, 256);
    frame(1, 10000, 1'b0);
    frame(1, -5, 1'b0);
    drain();

    // random backpressure, shadow bank rewritten mid-frame
    rnd_en = 1'b1;
    frame(2, 0, 1'b1);
    frame(2, 0, 1'b0);
    drain();
    rnd_en = 1'b0;

    // short line: eol at col 5 of row 1
    for (int c = 0; c < 8; c++) send(c, c == 0, c == 7);
    for (int c = 0; c < 6; c++) send(8 + c, 1'b0, c == 5);
    for (int c = 0; c < 8; c++) send(16 + c, 1'b0, c == 7);
    drain();
    chk("line_err_set", line_err, 1);
    chk("line_err_set_s2", line_err2, 1);

    frame(0, 0, 1'b0);
    drain();
    chk("line_err_sticky", line_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
